// File: rtl/datapath_pkg.sv
// Shared types and constants for the parametrised SimpleCISC datapath:
// ALU opcodes, memory-bus FSM states, flag bit positions and address selects.
package datapath_pkg;

  typedef enum logic [3:0] {
    ALU_PASS_A = 4'd0,
    ALU_PASS_B = 4'd1,
    ALU_ADD    = 4'd2,
    ALU_SUB    = 4'd3,
    ALU_AND    = 4'd4,
    ALU_OR     = 4'd5,
    ALU_XOR    = 4'd6,
    ALU_NOT_A  = 4'd7,
    ALU_SHL    = 4'd8,
    ALU_SHR    = 4'd9,
    ALU_INC_A  = 4'd10,
    ALU_DEC_A  = 4'd11
  } alu_func_t;

  typedef enum logic [1:0] {
    BUS_IDLE    = 2'd0,
    BUS_RD_WAIT = 2'd1,
    BUS_WR_WAIT = 2'd2
  } bus_state_t;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] ADDR_PC   = 2'd0;
  localparam logic [1:0] ADDR_MAR  = 2'd1;
  localparam logic [1:0] ADDR_SP   = 2'd2;
  localparam logic [1:0] ADDR_MAR2 = 2'd3;

endpackage

// File: rtl/alu_param.sv
// Combinational WIDTH-bit ALU. C is carry for add/inc, not-borrow for
// sub/dec and the shifted-out bit for shifts; V is signed overflow for add/sub/inc/dec.
module alu_param
  import datapath_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       func_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             c_o,
  output logic             v_o
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0] ext;

  always_comb begin
    ext      = '0;
    result_o = a_i;
    c_o      = 1'b0;
    v_o      = 1'b0;
    case (func_i)
      ALU_PASS_A: result_o = a_i;
      ALU_PASS_B: result_o = b_i;
      ALU_ADD: begin
        ext      = {1'b0, a_i} + {1'b0, b_i};
        result_o = ext[WIDTH-1:0];
        c_o      = ext[WIDTH];
        v_o      = (a_i[MSB] == b_i[MSB]) && (result_o[MSB] != a_i[MSB]);
      end
      ALU_SUB: begin
        ext      = {1'b0, a_i} - {1'b0, b_i};
        result_o = ext[WIDTH-1:0];
        c_o      = ~ext[WIDTH];
        v_o      = (a_i[MSB] != b_i[MSB]) && (result_o[MSB] != a_i[MSB]);
      end
      ALU_AND:   result_o = a_i & b_i;
      ALU_OR:    result_o = a_i | b_i;
      ALU_XOR:   result_o = a_i ^ b_i;
      ALU_NOT_A: result_o = ~a_i;
      ALU_SHL: begin
        result_o = {a_i[WIDTH-2:0], 1'b0};
        c_o      = a_i[MSB];
      end
      ALU_SHR: begin
        result_o = {1'b0, a_i[WIDTH-1:1]};
        c_o      = a_i[0];
      end
      ALU_INC_A: begin
        ext      = {1'b0, a_i} + (WIDTH+1)'(1);
        result_o = ext[WIDTH-1:0];
        c_o      = ext[WIDTH];
        v_o      = ~a_i[MSB] & result_o[MSB];
      end
      ALU_DEC_A: begin
        ext      = {1'b0, a_i} - (WIDTH+1)'(1);
        result_o = ext[WIDTH-1:0];
        c_o      = ~ext[WIDTH];
        v_o      = a_i[MSB] & ~result_o[MSB];
      end
      default: result_o = a_i;
    endcase
  end

endmodule

// File: rtl/datapath_param.sv
// Parametrised SimpleCISC datapath: register file, PC, SP, flags, MAR/MDR/IR
// and a handshaked memory-bus FSM with wait-state timeout and sticky error.
module datapath_param
  import datapath_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter int               NREGS    = 4,
  parameter logic [WIDTH-1:0] SP_RESET = '1,
  parameter int               WAIT_MAX = 8,
  localparam int              SEL_W    = $clog2(NREGS + 2)
) (
  input  logic             Clock,
  input  logic             nReset,
  inout  wire  [WIDTH-1:0] DataBus,
  output logic [WIDTH-1:0] Address,
  output logic [WIDTH-1:0] IR,
  output logic [3:0]       Flags,
  output logic             Busy,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             BusError,
  input  logic             MemAck,
  input  logic [3:0]       Function,
  input  logic             UpdateFlags,
  input  logic [SEL_W-1:0] SrcSel,
  input  logic [SEL_W-1:0] DstSel,
  input  logic             LoadDst,
  input  logic             LoadMAR,
  input  logic             LoadIR,
  input  logic             IncPC,
  input  logic             PushSP,
  input  logic             PopSP,
  input  logic [1:0]       AddrSel,
  input  logic             StartRead,
  input  logic             StartWrite,
  input  logic             ClearError
);

  localparam int               IDX_W    = $clog2(NREGS);
  localparam int               CNT_W    = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);
  localparam logic [SEL_W-1:0] SEL_PC   = SEL_W'(NREGS);
  localparam logic [SEL_W-1:0] SEL_SP   = SEL_W'(NREGS + 1);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] pc_q, sp_q, mar_q, mdr_q, ir_q, wdr_q, abuf_q;
  logic [3:0]       flags_q;
  logic             err_q, err_d;

  bus_state_t       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             start_rd, start_wr, start_clash, timeout, rd_done, bus_drive;

  logic [WIDTH-1:0] src_a, addr_mux, alu_res;
  logic             alu_c, alu_v;

  // Out-of-range selects read as zero.
  always_comb begin
    src_a = '0;
    if (SrcSel < SEL_PC)       src_a = regs_q[SrcSel[IDX_W-1:0]];
    else if (SrcSel == SEL_PC) src_a = pc_q;
    else if (SrcSel == SEL_SP) src_a = sp_q;
  end

  always_comb begin
    case (AddrSel)
      ADDR_PC: addr_mux = pc_q;
      ADDR_SP: addr_mux = sp_q;
      default: addr_mux = mar_q;
    endcase
  end

  alu_param #(.WIDTH(WIDTH)) u_alu (
    .func_i   (Function),
    .a_i      (src_a),
    .b_i      (mdr_q),
    .result_o (alu_res),
    .c_o      (alu_c),
    .v_o      (alu_v)
  );

  // Bus handshake: a start is accepted only in IDLE and holds the strobe for
  // the whole WAIT state; MemAck is sampled only while waiting and ends the
  // transaction on that edge, otherwise WAIT_MAX unacked cycles time it out.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q    <= BUS_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = '0;
    start_rd    = 1'b0;
    start_wr    = 1'b0;
    start_clash = 1'b0;
    timeout     = 1'b0;
    rd_done     = 1'b0;
    case (state_q)
      BUS_IDLE: begin
        start_clash = StartRead && StartWrite;
        start_rd    = StartRead && !StartWrite;
        start_wr    = StartWrite && !StartRead;
        if (start_rd)      state_d = BUS_RD_WAIT;
        else if (start_wr) state_d = BUS_WR_WAIT;
      end
      BUS_RD_WAIT, BUS_WR_WAIT: begin
        if (MemAck) begin
          state_d = BUS_IDLE;
          rd_done = (state_q == BUS_RD_WAIT);
        end else if (wait_cnt_q == CNT_LAST) begin
          state_d = BUS_IDLE;
          timeout = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = BUS_IDLE;
    endcase
  end

  always_comb begin
    Busy      = (state_q != BUS_IDLE);
    MemRead   = (state_q == BUS_RD_WAIT);
    MemWrite  = (state_q == BUS_WR_WAIT);
    bus_drive = (state_q == BUS_WR_WAIT);
  end

  assign DataBus  = bus_drive ? wdr_q : {WIDTH{1'bz}};
  assign Address  = Busy ? abuf_q : addr_mux;
  assign IR       = ir_q;
  assign Flags    = flags_q;
  assign BusError = err_q;

  // A new error event outranks ClearError in the same cycle.
  always_comb begin
    err_d = err_q;
    if (start_clash || timeout) err_d = 1'b1;
    else if (ClearError)        err_d = 1'b0;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      pc_q    <= '0;
      sp_q    <= SP_RESET;
      mar_q   <= '0;
      mdr_q   <= '0;
      ir_q    <= '0;
      wdr_q   <= '0;
      abuf_q  <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (LoadDst && DstSel == SEL_W'(i)) regs_q[i] <= alu_res;
      end
      if (LoadDst && DstSel == SEL_PC) pc_q <= alu_res;
      else if (IncPC)                  pc_q <= pc_q + 1'b1;
      if (LoadDst && DstSel == SEL_SP) sp_q <= alu_res;
      else if (PushSP && !PopSP)       sp_q <= sp_q - 1'b1;
      else if (PopSP && !PushSP)       sp_q <= sp_q + 1'b1;
      if (LoadMAR) mar_q <= alu_res;
      if (LoadIR)  ir_q  <= mdr_q;
      if (rd_done) mdr_q <= DataBus;
      if (start_rd || start_wr) abuf_q <= addr_mux;
      if (start_wr) wdr_q <= src_a;
      if (UpdateFlags) begin
        flags_q[FLAG_Z] <= (alu_res == '0);
        flags_q[FLAG_N] <= alu_res[WIDTH-1];
        flags_q[FLAG_C] <= alu_c;
        flags_q[FLAG_V] <= alu_v;
      end
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_datapath_param.sv
// Scenario bench for datapath_param: memory handshake, ALU/flags, stack, PC,
// timeout and error handling, checked against an expected-value queue.
module tb_datapath_param;
  import datapath_pkg::*;

  localparam int WIDTH    = 16;
  localparam int NREGS    = 4;
  localparam int WAIT_MAX = 8;
  localparam int SEL_W    = 3;

  logic              Clock = 1'b0;
  logic              nReset = 1'b0;
  wire  [WIDTH-1:0]  DataBus;
  logic [WIDTH-1:0]  Address, IR;
  logic [3:0]        Flags;
  logic              Busy, MemRead, MemWrite, BusError;
  logic              MemAck, UpdateFlags, LoadDst, LoadMAR, LoadIR, IncPC;
  logic              PushSP, PopSP, StartRead, StartWrite, ClearError;
  logic [3:0]        Function;
  logic [SEL_W-1:0]  SrcSel, DstSel;
  logic [1:0]        AddrSel;

  logic              mem_oe;
  logic [WIDTH-1:0]  mem_data;
  assign DataBus = mem_oe ? mem_data : {WIDTH{1'bz}};

  logic [WIDTH-1:0]  exp_q[$];
  logic [WIDTH-1:0]  exp;
  logic [WIDTH-1:0]  last_mdr;
  int                vectors = 0;
  int                miscompares = 0;
  int                busy_cycles;

  datapath_param #(.WIDTH(WIDTH), .NREGS(NREGS), .SP_RESET(16'hFFFF), .WAIT_MAX(WAIT_MAX)) dut (
    .Clock(Clock), .nReset(nReset), .DataBus(DataBus), .Address(Address), .IR(IR),
    .Flags(Flags), .Busy(Busy), .MemRead(MemRead), .MemWrite(MemWrite),
    .BusError(BusError), .MemAck(MemAck), .Function(Function),
    .UpdateFlags(UpdateFlags), .SrcSel(SrcSel), .DstSel(DstSel), .LoadDst(LoadDst),
    .LoadMAR(LoadMAR), .LoadIR(LoadIR), .IncPC(IncPC), .PushSP(PushSP), .PopSP(PopSP),
    .AddrSel(AddrSel), .StartRead(StartRead), .StartWrite(StartWrite),
    .ClearError(ClearError)
  );

  // ---------------- clock / reset ----------------
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual running, required finished");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_ctrl();
    MemAck = 0; Function = ALU_PASS_A; UpdateFlags = 0; SrcSel = '0; DstSel = '0;
    LoadDst = 0; LoadMAR = 0; LoadIR = 0; IncPC = 0; PushSP = 0; PopSP = 0;
    AddrSel = ADDR_PC; StartRead = 0; StartWrite = 0; ClearError = 0;
    mem_oe = 0; mem_data = '0;
  endtask

  task automatic bus_read(input logic [WIDTH-1:0] d);
    StartRead = 1;
    tick();
    StartRead = 0; MemAck = 1; mem_oe = 1; mem_data = d;
    tick();
    MemAck = 0; mem_oe = 0;
    last_mdr = d;
  endtask

  task automatic set_reg(input int sel, input logic [WIDTH-1:0] d);
    bus_read(d);
    Function = ALU_PASS_B; DstSel = SEL_W'(sel); LoadDst = 1;
    tick();
    LoadDst = 0; Function = ALU_PASS_A;
  endtask

  // Copies a source onto Address through MAR.
  task automatic peek_src(input int sel);
    SrcSel = SEL_W'(sel); Function = ALU_PASS_A; LoadMAR = 1;
    tick();
    LoadMAR = 0; AddrSel = ADDR_MAR;
    #1;
  endtask

  function automatic logic [19:0] alu_model(input logic [3:0] f, input logic [15:0] a,
                                            input logic [15:0] b);
    int ua, ub, sa, sb, r;
    logic c, v;
    logic [15:0] res;
    ua = int'(a); ub = int'(b); sa = int'($signed(a)); sb = int'($signed(b));
    c = 0; v = 0; r = ua;
    case (f)
      4'd1: r = ub;
      4'd2: begin r = ua + ub; c = (r > 65535); v = (sa + sb > 32767) || (sa + sb < -32768); end
      4'd3: begin r = ua - ub; c = (ua >= ub); v = (sa - sb > 32767) || (sa - sb < -32768); end
      4'd4: r = int'(a & b);
      4'd5: r = int'(a | b);
      4'd6: r = int'(a ^ b);
      4'd7: r = 65535 - ua;
      4'd8: begin r = ua * 2; c = (ua >= 32768); end
      4'd9: begin r = ua / 2; c = (ua % 2) == 1; end
      4'd10: begin r = ua + 1; c = (ua == 65535); v = (sa == 32767); end
      4'd11: begin r = ua - 1; c = (ua != 0); v = (sa == -32768); end
      default: r = ua;
    endcase
    res = r[15:0];
    return {res == 16'h0, res[15], c, v, res};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_ctrl();
    nReset = 0;
    repeat (2) @(posedge Clock);
    #1 nReset = 1;
    exp_q.push_back(16'h0);
    exp = exp_q.pop_front(); vectors++;
    if (IR !== exp) begin miscompares++; $display("FAIL reset_ir: IR=%h expected %h", IR, exp); end
    AddrSel = ADDR_SP; exp_q.push_back(16'hFFFF); #1;
    exp = exp_q.pop_front(); vectors++;
    if (Address !== exp) begin miscompares++; $display("FAIL reset_sp: Address=%h expected %h", Address, exp); end
    // Start a read and set Z, then reset in the middle of the wait.
    AddrSel = ADDR_PC; StartRead = 1; UpdateFlags = 1; SrcSel = 3'd0;
    exp_q.push_back(16'h1); exp_q.push_back(16'h8);
    tick();
    StartRead = 0; UpdateFlags = 0;
    exp = exp_q.pop_front(); vectors++;
    if ({15'b0, MemRead} !== exp) begin miscompares++; $display("FAIL pre_reset_memread: MemRead=%b expected %h", MemRead, exp); end
    exp = exp_q.pop_front(); vectors++;
    if ({12'b0, Flags} !== exp) begin miscompares++; $display("FAIL pre_reset_flags: Flags=%h expected %h", Flags, exp); end
    #2 nReset = 0;
    exp_q.push_back(16'h0); exp_q.push_back(16'h0); exp_q.push_back(16'h0);
    #1;
    exp = exp_q.pop_front(); vectors++;
    if ({15'b0, MemRead} !== exp) begin miscompares++; $display("FAIL async_memread: MemRead=%b expected %h", MemRead, exp); end
    exp = exp_q.pop_front(); vectors++;
    if ({15'b0, Busy} !== exp) begin miscompares++; $display("FAIL async_busy: Busy=%b expected %h", Busy, exp); end
    exp = exp_q.pop_front(); vectors++;
    if ({12'b0, Flags} !== exp) begin miscompares++; $display("FAIL async_flags: Flags=%h expected %h", Flags, exp); end
    AddrSel = ADDR_SP; exp_q.push_back(16'hFFFF); #1;
    exp = exp_q.pop_front(); vectors++;
    if (Address !== exp) begin miscompares++; $display("FAIL async_sp: Address=%h expected %h", Address, exp); end
    AddrSel = ADDR_PC;
    tick();
    nReset = 1;
    exp_q.push_back(16'h0);
    exp = exp_q.pop_front(); vectors++;
    if ({15'b0, BusError} !== exp) begin miscompares++; $display("FAIL reset_buserror: BusError=%b expected %h", BusError, exp); end
  endtask

  task automatic test_read_wait();
    AddrSel = ADDR_PC; StartRead = 1;
    tick();
    StartRead = 0; AddrSel = ADDR_SP;
    busy_cycles = 0;
    for (int k = 1; k <= 20 && Busy; k++) begin
      busy_cycles++;
      exp_q.push_back(16'h0000);
      exp = exp_q.pop_front(); vectors++;
      if (Address !== exp) begin miscompares++; $display("FAIL read_addr_hold: Address=%h expected %h", Address, exp); end
      if (k == 3) begin MemAck = 1; mem_oe = 1; mem_data = 16'hBEEF; end
      tick();
      MemAck = 0; mem_oe = 0;
    end
    exp_q.push_back(16'd3);
    exp = exp_q.pop_front(); vectors++;
    if (16'(busy_cycles) !== exp) begin miscompares++; $display("FAIL read_busy_cycles: busy=%0d expected %0d", busy_cycles, exp); end
    exp_q.push_back(16'hFFFF);
    exp = exp_q.pop_front(); vectors++;
    if (Address !== exp) begin miscompares++; $display("FAIL read_addr_release: Address=%h expected %h", Address, exp); end
    LoadIR = 1; exp_q.push_back(16'hBEEF);
    tick();
    LoadIR = 0; last_mdr = 16'hBEEF;
    exp = exp_q.pop_front(); vectors++;
    if (IR !== exp) begin miscompares++; $display("FAIL read_ir: IR=%h expected %h", IR, exp); end
  endtask

  task automatic test_alu_add_sub();
    idle_ctrl();
    set_reg(1, 16'h7FFF);
    bus_read(16'h0001);
    SrcSel = 3'd1; Function = ALU_ADD; DstSel = 3'd2; LoadDst = 1; UpdateFlags = 1;
    exp_q.push_back(16'h0005); exp_q.push_back(16'h8000);
    tick();
    LoadDst = 0; UpdateFlags = 0;
    exp = exp_q.pop_front(); vectors++;
    if ({12'b0, Flags} !== exp) begin miscompares++; $display("FAIL add_flags: Flags=%h expected %h", Flags, exp); end
    peek_src(2);
    exp = exp_q.pop_front(); vectors++;
    if (Address !== exp) begin miscompares++; $display("FAIL add_result: R2=%h expected %h", Address, exp); end
    SrcSel = 3'd2; Function = ALU_SUB; DstSel = 3'd3; LoadDst = 1; UpdateFlags = 1;
    exp_q.push_back(16'h0003); exp_q.push_back(16'h7FFF);
    tick();
    LoadDst = 0; UpdateFlags = 0;
    exp = exp_q.pop_front(); vectors++;
    if ({12'b0, Flags} !== exp) begin miscompares++; $display("FAIL sub_flags: Flags=%h expected %h", Flags, exp); end
    peek_src(3);
    exp = exp_q.pop_front(); vectors++;
    if (Address !== exp) begin miscompares++; $display("FAIL sub_result: R3=%h expected %h", Address, exp); end
  endtask

  task automatic test_alu_random();
    logic [15:0] edge_a [4];
    logic [15:0] a, b;
    logic [3:0]  f;
    logic [19:0] m;
    edge_a[0] = 16'h0000; edge_a[1] = 16'hFFFF; edge_a[2] = 16'h8000; edge_a[3] = 16'h7FFF;
    for (int i = 0; i < 12; i++) begin
      idle_ctrl();
      a = (i < 4) ? edge_a[i] : 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(0, 65535));
      f = 4'($urandom_range(0, 15));
      set_reg(0, a);
      bus_read(b);
      SrcSel = 3'd0; Function = f; DstSel = 3'd1; LoadDst = 1; UpdateFlags = 1;
      m = alu_model(f, a, b);
      exp_q.push_back({12'b0, m[19:16]}); exp_q.push_back(m[15:0]);
      tick();
      LoadDst = 0; UpdateFlags = 0;
      exp = exp_q.pop_front(); vectors++;
      if ({12'b0, Flags} !== exp) begin miscompares++; $display("FAIL alu_flags f=%0d a=%h b=%h: Flags=%h expected %h", f, a, b, Flags, exp); end
      peek_src(1);
      exp = exp_q.pop_front(); vectors++;
      if (Address !== exp) begin miscompares++; $display("FAIL alu_result f=%0d a=%h b=%h: result=%h expected %h", f, a, b, Address, exp); end
    end
  endtask

  task automatic test_stack();
    idle_ctrl();
    PushSP = 1;
    tick();
    PushSP = 0; AddrSel = ADDR_SP; exp_q.push_back(16'hFFFE); #1;
    exp = exp_q.pop_front(); vectors++;
    if (Address !== exp) begin miscompares++; $display("FAIL push_sp: SP=%h expected %h", Address, exp); end
    SrcSel = 3'd2; StartWrite = 1;
    tick();
    StartWrite = 0; SrcSel = 3'd0; AddrSel = ADDR_PC;
    busy_cycles = 0;
    for (int k = 1; k <= 20 && Busy; k++) begin
      busy_cycles++;
      exp_q.push_back(16'h1); exp_q.push_back(16'hFFFE); exp_q.push_back(16'h8000);
      exp = exp_q.pop_front(); vectors++;
      if ({15'b0, MemWrite} !== exp) begin miscompares++; $display("FAIL wr_strobe: MemWrite=%b expected %h", MemWrite, exp); end
      exp = exp_q.pop_front(); vectors++;
      if (Address !== exp) begin miscompares++; $display("FAIL wr_addr: Address=%h expected %h", Address, exp); end
      exp = exp_q.pop_front(); vectors++;
      if (DataBus !== exp) begin miscompares++; $display("FAIL wr_data: DataBus=%h expected %h", DataBus, exp); end
      if (k == 2) MemAck = 1;
      tick();
      MemAck = 0;
    end
    exp_q.push_back(16'd2); exp_q.push_back(16'h0);
    exp = exp_q.pop_front(); vectors++;
    if (16'(busy_cycles) !== exp) begin miscompares++; $display("FAIL wr_busy_cycles: busy=%0d expected %0d", busy_cycles, exp); end
    exp = exp_q.pop_front(); vectors++;
    if ({15'b0, MemWrite} !== exp) begin miscompares++; $display("FAIL wr_end: MemWrite=%b expected %h", MemWrite, exp); end
    PopSP = 1; AddrSel = ADDR_SP; exp_q.push_back(16'hFFFF);
    tick();
    PopSP = 0;
    exp = exp_q.pop_front(); vectors++;
    if (Address !== exp) begin miscompares++; $display("FAIL pop_sp: SP=%h expected %h", Address, exp); end
    PushSP = 1; PopSP = 1; exp_q.push_back(16'hFFFF);
    tick();
    PushSP = 0; PopSP = 0;
    exp = exp_q.pop_front(); vectors++;
    if (Address !== exp) begin miscompares++; $display("FAIL push_pop_sp: SP=%h expected %h", Address, exp); end
    bus_read(16'h1000);
    Function = ALU_PASS_B; DstSel = 3'd5; LoadDst = 1; PushSP = 1; AddrSel = ADDR_SP;
    exp_q.push_back(16'h1000);
    tick();
    LoadDst = 0; PushSP = 0;
    exp = exp_q.pop_front(); vectors++;
    if (Address !== exp) begin miscompares++; $display("FAIL load_sp_priority: SP=%h expected %h", Address, exp); end
  endtask

  task automatic test_timeout();
    idle_ctrl();
    StartRead = 1;
    tick();
    StartRead = 0; mem_oe = 1; mem_data = 16'hDEAD;
    busy_cycles = 0;
    for (int k = 1; k <= 30 && Busy; k++) begin
      busy_cycles++;
      tick();
    end
    mem_oe = 0;
    exp_q.push_back(16'(WAIT_MAX)); exp_q.push_back(16'h1);
    exp = exp_q.pop_front(); vectors++;
    if (16'(busy_cycles) !== exp) begin miscompares++; $display("FAIL timeout_cycles: busy=%0d expected %0d", busy_cycles, exp); end
    exp = exp_q.pop_front(); vectors++;
    if ({15'b0, BusError} !== exp) begin miscompares++; $display("FAIL timeout_error: BusError=%b expected %h", BusError, exp); end
    LoadIR = 1; exp_q.push_back(last_mdr);
    tick();
    LoadIR = 0;
    exp = exp_q.pop_front(); vectors++;
    if (IR !== exp) begin miscompares++; $display("FAIL timeout_mdr: IR=%h expected %h", IR, exp); end
    ClearError = 1; exp_q.push_back(16'h0);
    tick();
    ClearError = 0;
    exp = exp_q.pop_front(); vectors++;
    if ({15'b0, BusError} !== exp) begin miscompares++; $display("FAIL clear_error: BusError=%b expected %h", BusError, exp); end
    StartRead = 1; StartWrite = 1;
    exp_q.push_back(16'h0); exp_q.push_back(16'h0); exp_q.push_back(16'h1);
    tick();
    StartRead = 0; StartWrite = 0;
    exp = exp_q.pop_front(); vectors++;
    if ({15'b0, MemRead} !== exp) begin miscompares++; $display("FAIL clash_read: MemRead=%b expected %h", MemRead, exp); end
    exp = exp_q.pop_front(); vectors++;
    if ({15'b0, MemWrite} !== exp) begin miscompares++; $display("FAIL clash_write: MemWrite=%b expected %h", MemWrite, exp); end
    exp = exp_q.pop_front(); vectors++;
    if ({15'b0, BusError} !== exp) begin miscompares++; $display("FAIL clash_error: BusError=%b expected %h", BusError, exp); end
    ClearError = 1; tick(); ClearError = 0;
    StartRead = 1; StartWrite = 1; ClearError = 1; exp_q.push_back(16'h1);
    tick();
    StartRead = 0; StartWrite = 0; ClearError = 0;
    exp = exp_q.pop_front(); vectors++;
    if ({15'b0, BusError} !== exp) begin miscompares++; $display("FAIL set_beats_clear: BusError=%b expected %h", BusError, exp); end
    ClearError = 1; tick(); ClearError = 0;
  endtask

  task automatic test_pc();
    idle_ctrl();
    set_reg(4, 16'hFFFF);
    AddrSel = ADDR_PC; exp_q.push_back(16'hFFFF); #1;
    exp = exp_q.pop_front(); vectors++;
    if (Address !== exp) begin miscompares++; $display("FAIL pc_load: PC=%h expected %h", Address, exp); end
    IncPC = 1; exp_q.push_back(16'h0000);
    tick();
    IncPC = 0;
    exp = exp_q.pop_front(); vectors++;
    if (Address !== exp) begin miscompares++; $display("FAIL pc_wrap: PC=%h expected %h", Address, exp); end
    bus_read(16'h1234);
    Function = ALU_PASS_B; DstSel = 3'd4; LoadDst = 1; IncPC = 1; exp_q.push_back(16'h1234);
    tick();
    LoadDst = 0; IncPC = 0;
    exp = exp_q.pop_front(); vectors++;
    if (Address !== exp) begin miscompares++; $display("FAIL pc_load_priority: PC=%h expected %h", Address, exp); end
    IncPC = 1; exp_q.push_back(16'h1235);
    tick();
    IncPC = 0;
    exp = exp_q.pop_front(); vectors++;
    if (Address !== exp) begin miscompares++; $display("FAIL pc_inc: PC=%h expected %h", Address, exp); end
  endtask

  task automatic test_out_of_range();
    idle_ctrl();
    bus_read(16'h5555);
    Function = ALU_PASS_B; DstSel = 3'd6; LoadDst = 1;
    tick();
    LoadDst = 0;
    exp_q.push_back(16'h8000);
    peek_src(2);
    exp = exp_q.pop_front(); vectors++;
    if (Address !== exp) begin miscompares++; $display("FAIL dst_out_of_range: R2=%h expected %h", Address, exp); end
    exp_q.push_back(16'h0000);
    peek_src(7);
    exp = exp_q.pop_front(); vectors++;
    if (Address !== exp) begin miscompares++; $display("FAIL src_out_of_range: A=%h expected %h", Address, exp); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    last_mdr = '0;
    idle_ctrl();
    test_reset();
    test_read_wait();
    test_alu_add_sub();
    test_alu_random();
    test_stack();
    test_timeout();
    test_pc();
    test_out_of_range();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
